// File: rtl/demux_stream_1ton.sv
// Registered 1:N stream demultiplexer. Each beat is routed by s_sel or by a
// round-robin pointer into a one-entry output register per channel.

module demux_stream_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             rdy_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dout_o
);
  logic             vld_q;
  logic [WIDTH-1:0] data_q;

  // A write wins over a drain so a slot can be refilled in the cycle it empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (wr_i) begin
      vld_q  <= 1'b1;
      data_q <= din_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign dout_o = data_q;
endmodule

module demux_stream_1ton #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic [SELW-1:0]      s_sel,
  output logic [NCH-1:0]       m_valid,
  input  logic [NCH-1:0]       m_ready,
  output logic [NCH*WIDTH-1:0] m_data,
  output logic                 err_drop,
  output logic [SELW-1:0]      rr_ptr
);
  localparam int SLOTS = 1 << SELW;

  logic [NCH-1:0]   free, wr;
  logic [SLOTS-1:0] free_ext;
  logic [SELW-1:0]  tgt, rr_ptr_q, rr_ptr_d;
  logic             illegal, acc, err_drop_q;

  assign tgt      = mode ? rr_ptr_q : s_sel;
  assign illegal  = !mode && (int'(s_sel) >= NCH);
  assign free     = ~m_valid | m_ready;
  // Padded so an out-of-range select never indexes past the slot vector.
  assign free_ext = SLOTS'(free);
  assign s_ready  = rst_n && (illegal || free_ext[tgt]);
  assign acc      = s_valid && s_ready;
  assign rr_ptr_d = (rr_ptr_q == SELW'(NCH - 1)) ? '0 : rr_ptr_q + 1'b1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = acc && !illegal && (tgt == SELW'(i));

    demux_stream_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_i   (wr[i]),
      .rdy_i  (m_ready[i]),
      .din_i  (s_data),
      .vld_o  (m_valid[i]),
      .dout_o (m_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= acc && illegal;
      if (acc && mode) rr_ptr_q <= rr_ptr_d;
    end
  end

  assign err_drop = err_drop_q;
  assign rr_ptr   = rr_ptr_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: a 4-channel and a 3-channel instance,
// expected beats queued per channel and checked by a negedge monitor.
module tb_demux_stream_1ton;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       mode4, sv4, sr4, err4;
  logic [7:0] sd4;
  logic [1:0] ss4, rr4;
  logic [3:0] mv4, mr4;
  logic [31:0] md4;

  logic       mode3, sv3, sr3, err3;
  logic [7:0] sd3;
  logic [1:0] ss3, rr3;
  logic [2:0] mv3, mr3;
  logic [23:0] md3;

  demux_stream_1ton #(.WIDTH(8), .NCH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .s_valid(sv4), .s_ready(sr4),
    .s_data(sd4), .s_sel(ss4), .m_valid(mv4), .m_ready(mr4), .m_data(md4),
    .err_drop(err4), .rr_ptr(rr4));

  demux_stream_1ton #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .s_valid(sv3), .s_ready(sr3),
    .s_data(sd3), .s_sel(ss3), .m_valid(mv3), .m_ready(mr3), .m_data(md3),
    .err_drop(err3), .rr_ptr(rr3));

  int nvec = 0, nerr = 0;
  int rr_m = 0;
  int last_wait = 0;
  logic [7:0] q4[4][$];
  logic [7:0] q3[3][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake on an output channel must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (mv4[i] && mr4[i]) begin
          if (q4[i].size() == 0) begin
            nvec++; nerr++;
            $display("FAIL dut4 ch%0d unexpected beat: got %0h expected none", i, md4[i*8 +: 8]);
          end else chk($sformatf("dut4 ch%0d data", i), 32'(md4[i*8 +: 8]), 32'(q4[i].pop_front()));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (mv3[i] && mr3[i]) begin
          if (q3[i].size() == 0) begin
            nvec++; nerr++;
            $display("FAIL dut3 ch%0d unexpected beat: got %0h expected none", i, md3[i*8 +: 8]);
          end else chk($sformatf("dut3 ch%0d data", i), 32'(md3[i*8 +: 8]), 32'(q3[i].pop_front()));
        end
      end
    end
  end

  // Present one beat on dut4, wait (bounded) for acceptance, then check 1-cycle latency.
  task automatic send4(input logic m, input logic [1:0] sel, input logic [7:0] d);
    int tgt;
    bit ok;
    ok = 1'b0;
    last_wait = -1;
    mode4 = m; ss4 = sel; sd4 = d; sv4 = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = sr4;
      last_wait++;
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL send4 timeout: s_ready 0 expected 1");
      sv4 = 1'b0;
      return;
    end
    tgt = m ? rr_m : int'(sel);
    if (m) chk("dut4 rr_ptr", 32'(rr4), rr_m);
    q4[tgt].push_back(d);
    if (m) rr_m = (rr_m == 3) ? 0 : rr_m + 1;
    @(posedge clk); #1;
    sv4 = 1'b0;
    chk("latency valid", 32'(mv4[tgt]), 1);
    chk("latency data", 32'(md4[tgt*8 +: 8]), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    mode4 = 0; sv4 = 0; sd4 = 0; ss4 = 0; mr4 = 0;
    mode3 = 0; sv3 = 0; sd3 = 0; ss3 = 0; mr3 = 0;
    #1 rst_n = 1'b0;
    sv4 = 1'b1; mr4 = 4'hF;
    #2;
    chk("reset m_valid", 32'(mv4), 0);
    chk("reset m_data", md4, 0);
    chk("reset err_drop", 32'(err4), 0);
    chk("reset rr_ptr", 32'(rr4), 0);
    chk("reset s_ready", 32'(sr4), 0);
    chk("reset dut3 m_valid", 32'(mv3), 0);
    sv4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Select walk, all consumers ready: every beat accepted without waiting.
    mr4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send4(1'b0, 2'(i), 8'hA0 + 8'(i));
      chk("walk no stall", last_wait, 0);
    end

    // Backpressure isolation on ch1.
    mr4 = 4'b1101;
    send4(1'b0, 2'd1, 8'h11);
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold valid ch1", 32'(mv4[1]), 1);
      chk("hold data ch1", 32'(md4[15:8]), 32'h11);
    end
    mode4 = 0; ss4 = 2'd1; sd4 = 8'h33; sv4 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall s_ready ch1", 32'(sr4), 0);
    end
    @(posedge clk); #1;
    sv4 = 1'b0;
    send4(1'b0, 2'd2, 8'h22);
    chk("other channel no stall", last_wait, 0);
    mr4 = 4'hF;
    send4(1'b0, 2'd1, 8'h33);
    chk("drain+refill same cycle", last_wait, 0);

    // Round-robin wrap with s_sel scrambled.
    for (int i = 0; i < 6; i++) send4(1'b1, 2'($urandom_range(0, 3)), 8'hD0 + 8'(i));
    chk("rr after wrap", 32'(rr4), 2);

    // Back-to-back to ch0: no bubbles.
    for (int i = 0; i < 4; i++) begin
      send4(1'b0, 2'd0, 8'hB0 + 8'(i));
      chk("b2b no stall", last_wait, 0);
    end
    chk("rr held in mode 0", 32'(rr4), 2);

    // NCH=3: illegal select is sunk and flagged for one cycle.
    mode3 = 0; ss3 = 2'd3; sd3 = 8'hEE; sv3 = 1'b1; mr3 = 3'b111;
    @(negedge clk);
    chk("nch3 illegal s_ready", 32'(sr3), 1);
    @(posedge clk); #1;
    sv3 = 1'b0;
    chk("nch3 err_drop pulse", 32'(err3), 1);
    chk("nch3 no m_valid", 32'(mv3), 0);
    @(posedge clk); #1;
    chk("nch3 err_drop clears", 32'(err3), 0);
    chk("nch3 still no m_valid", 32'(mv3), 0);

    // NCH=3 round robin wraps 2 -> 0.
    mode3 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sv3 = 1'b1; sd3 = 8'h30 + 8'(j); ss3 = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("nch3 rr_ptr", 32'(rr3), j % 3);
      chk("nch3 s_ready", 32'(sr3), 1);
      if (sr3) q3[j % 3].push_back(sd3);
      @(posedge clk); #1;
      sv3 = 1'b0;
    end
    chk("nch3 rr final", 32'(rr3), 2);

    // Async reset with three channels full.
    mr4 = 4'h0;
    send4(1'b0, 2'd0, 8'hC0);
    send4(1'b0, 2'd1, 8'hC1);
    send4(1'b0, 2'd2, 8'hC2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset m_valid", 32'(mv4), 0);
    chk("async reset rr_ptr", 32'(rr4), 0);
    chk("async reset s_ready", 32'(sr4), 0);
    for (int i = 0; i < 4; i++) q4[i].delete();
    rr_m = 0;
    @(negedge clk); rst_n = 1'b1; mr4 = 4'hF;
    @(posedge clk); #1;
    send4(1'b1, 2'd3, 8'h5A);
    chk("post-reset no stall", last_wait, 0);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("dut4 q%0d drained", i), q4[i].size(), 0);
    for (int i = 0; i < 3; i++) chk($sformatf("dut3 q%0d drained", i), q3[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1ton

Overview:
Registered, parametrised 1:N stream demultiplexer with valid/ready handshakes on the input and on each output channel. Each input beat goes to one output channel, picked either by an explicit select or by a round-robin pointer. Each channel has a one-entry output register, so a stalled channel blocks only beats aimed at that channel. Used wherever one producer feeds several independent consumers.

Parameters:
WIDTH, 8, data width in bits (>=1)
NCH, 4, number of output channels (2..16; need not be a power of two)
SELW, $clog2(NCH), select width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = select-driven routing, 1 = round-robin routing
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid & s_ready
s_data  input  WIDTH  input payload
s_sel  input  SELW  target channel in mode 0; ignored in mode 1
m_valid  output  NCH  per-channel output valid, bit i = channel i
m_ready  input  NCH  per-channel consumer ready
m_data  output  NCH*WIDTH  per-channel payload, channel i at bits [i*WIDTH +: WIDTH]
err_drop  output  1  one-cycle pulse: beat accepted with illegal select and discarded
rr_ptr  output  SELW  current round-robin pointer (status)

Behaviour:
- Reset (rst_n low, asynchronous): m_valid = 0, m_data = 0, err_drop = 0, rr_ptr = 0. s_ready is forced to 0 while rst_n is low.
- Target channel: tgt = s_sel when mode = 0; tgt = rr_ptr when mode = 1.
- Illegal select: mode = 0 and s_sel >= NCH. This is possible only when NCH is not a power of two.
- Channel slot i is free when m_valid[i] = 0, or when m_valid[i] & m_ready[i] (draining this cycle).
- s_ready = slot[tgt] free. For an illegal select, s_ready = 1 (the beat is sunk).
- s_ready is combinational from mode, s_sel, rr_ptr, m_valid and m_ready. It never depends on s_valid.
- Accept (s_valid & s_ready), legal target:
  - next cycle m_valid[tgt] = 1 and m_data[tgt] = s_data.
  - Latency is exactly 1 clock from accept to visible m_valid.
- Accept, illegal target: no channel is written. err_drop = 1 for the following cycle only.
- Output drain: m_valid[i] & m_ready[i] with no new write to i -> m_valid[i] = 0 next cycle. m_data[i] holds its last value.
- Drain and refill in the same cycle on one channel: m_valid stays 1 and m_data takes the new beat. Full throughput, no bubble.
- Channels are independent. Any number may drain in one cycle; at most one is written per cycle.
- Holding: while m_valid[i] = 1 and m_ready[i] = 0, m_data[i] is stable.
- Round-robin pointer:
  - Advances only on an accepted beat in mode 1: rr_ptr = (rr_ptr == NCH-1) ? 0 : rr_ptr + 1. Wraps at NCH, not at 2^SELW.
  - Holds when mode = 0 or when there is no accept.
  - Does not skip a blocked channel: mode 1 with target slot full -> s_ready = 0 and the input stalls.
- Mode change: takes effect combinationally in the same cycle. No state is flushed and rr_ptr is preserved across mode changes.
- Reset mid-operation: all pending output beats are discarded immediately (m_valid = 0). No beat is replayed after reset.
- No combinational path from s_valid to any output.

Test Plan:
- Select walk (WIDTH=8, NCH=4, mode=0, all m_ready=1): send data A0,A1,A2,A3 with sel 0,1,2,3 on consecutive cycles -> one cycle later each m_valid[i] pulses once with m_data[i] = A_i; s_ready stays 1 throughout.
- Backpressure isolation: m_ready[1]=0; send 0x11 to ch1 -> m_valid[1]=1 holding 0x11. A second beat to ch1 -> s_ready=0, stalled. A beat 0x22 to ch2 is accepted. Release m_ready[1] -> ch1 drains, the stalled beat is accepted the same cycle and appears next cycle.
- Round-robin wrap (mode=1, NCH=4): 6 beats D0..D5 -> routed to ch 0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2; s_sel toggled randomly with no effect.
- Non-power-of-two (NCH=3, SELW=2):
  - mode=0, s_sel=3 -> accepted, err_drop=1 for one cycle, no m_valid asserted.
  - mode=1 -> rr_ptr wraps 2 -> 0.
- Back-to-back same channel (m_ready[0]=1): 4 consecutive beats to ch0 -> m_valid[0] stays high 4 cycles with each beat in order, no bubbles.
- Async reset mid-stream: m_ready=0 with 3 channels full; assert rst_n=0 between clock edges -> m_valid=0, rr_ptr=0 and s_ready=0 immediately. After release, first beat routes with 1-cycle latency.
